// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// The master side issues operands; the slave side returns the result and flags.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             overflow;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow, overflow
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow, overflow
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one bit per clock, with a registered borrow.
// Result, final borrow and signed overflow register on the completing edge and hold until the next one.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_subtractor_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_a, r_b, r_res, r_diff;
    logic [CW-1:0]    r_cnt;
    logic             r_br, r_borrow, r_ovf, r_amsb, r_bmsb;
    logic             w_ai, w_bi, w_d, w_br_nxt, w_last, w_accept;

    assign w_ai     = r_a[0];
    assign w_bi     = r_b[0];
    assign w_d      = w_ai ^ w_bi ^ r_br;
    assign w_br_nxt = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_br);
    assign w_last   = (r_state == S_RUN) && (r_cnt == CW'(WIDTH - 1));
    // DONE behaves like IDLE for acceptance, which is what gives back-to-back issue.
    assign w_accept = (r_state != S_RUN) && bus.start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        bus.busy = 1'b0;
        bus.done = 1'b0;
        case (r_state)
            S_IDLE: w_next = bus.start ? S_RUN : S_IDLE;
            S_RUN: begin
                bus.busy = 1'b1;
                if (w_last) w_next = S_DONE;
            end
            S_DONE: begin
                bus.done = 1'b1;
                w_next   = bus.start ? S_RUN : S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_diff   <= '0;
            r_cnt    <= '0;
            r_br     <= 1'b0;
            r_borrow <= 1'b0;
            r_ovf    <= 1'b0;
            r_amsb   <= 1'b0;
            r_bmsb   <= 1'b0;
        end else if (w_accept) begin
            r_a    <= bus.a;
            r_b    <= bus.b;
            r_amsb <= bus.a[WIDTH-1];
            r_bmsb <= bus.b[WIDTH-1];
            r_res  <= '0;
            r_br   <= 1'b0;
            r_cnt  <= '0;
        end else if (r_state == S_RUN) begin
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_res <= {w_d, r_res[WIDTH-1:1]};
            r_br  <= w_br_nxt;
            if (w_last) begin
                // w_d is the result MSB, so overflow needs no wait for r_res to settle.
                r_diff   <= {w_d, r_res[WIDTH-1:1]};
                r_borrow <= w_br_nxt;
                r_ovf    <= (r_amsb != r_bmsb) && (w_d != r_amsb);
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign bus.diff     = r_diff;
    assign bus.borrow   = r_borrow;
    assign bus.overflow = r_ovf;
endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench: WIDTH=8 vector table and corner sequences, then WIDTH=4 exhaustive.
module tb_serial_subtractor;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(8)) if8();
    serial_subtractor_if #(.WIDTH(4)) if4();

    serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
    serial_subtractor #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));

    typedef struct {
        logic [31:0] diff;
        logic        bo;
        logic        ov;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] diff;
        logic       bo;
        logic       ov;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[8];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic pop_cmp8(input string nm);
        exp_t e;
        if (sb.size() == 0) begin
            chk({nm, "_sb_empty"}, 0, 1);
            return;
        end
        e = sb.pop_front();
        chk({nm, "_diff"},  {24'h0, if8.diff}, e.diff);
        chk({nm, "_borrow"}, {31'h0, if8.borrow}, {31'h0, e.bo});
        chk({nm, "_ovf"},    {31'h0, if8.overflow}, {31'h0, e.ov});
    endtask

    // Entered at the negedge after an accept edge; returns at the negedge where done is seen.
    task automatic wait8(input bit hold_en, input logic [7:0] hold_v, output int lat, output int bsy);
        lat = 0;
        bsy = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if8.start = 1'b0;
            if (if8.busy && if8.done) chk("busy_done_overlap", 1, 0);
            if (if8.done) return;
            if (if8.busy) bsy++;
            if (hold_en) chk("diff_hold", {24'h0, if8.diff}, {24'h0, hold_v});
        end
        chk("timeout8", 0, 1);
        lat = -1;
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input exp_t e, input string nm);
        int lat, bsy;
        if8.start = 1'b1;
        if8.a     = a;
        if8.b     = b;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        if8.start = 1'b0;
        chk({nm, "_accept_busy"}, {31'h0, if8.busy}, 1);
        wait8(1'b0, 8'h00, lat, bsy);
        chk({nm, "_latency"}, lat, 8);
        chk({nm, "_busy_cycles"}, bsy + 1, 8);
        pop_cmp8(nm);
        @(posedge clk);
        @(negedge clk);
        chk({nm, "_done_1cyc"}, {31'h0, if8.done}, 0);
    endtask

    task automatic op4(input logic [3:0] a, input logic [3:0] b);
        int   sa, sbv, r, lat;
        exp_t e, g;
        sa  = (a >= 8) ? int'(a) - 16 : int'(a);
        sbv = (b >= 8) ? int'(b) - 16 : int'(b);
        r   = sa - sbv;
        e.diff = 32'((int'(a) - int'(b)) & 15);
        e.bo   = (a < b);
        e.ov   = (r < -8) || (r > 7);
        if4.start = 1'b1;
        if4.a     = a;
        if4.b     = b;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        if4.start = 1'b0;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (if4.done) begin
                lat = i;
                break;
            end
        end
        if (lat < 0) chk("timeout4", 0, 1);
        chk("w4_latency", lat, 4);
        g = sb.pop_front();
        if ({28'h0, if4.diff} !== g.diff || if4.borrow !== g.bo || if4.overflow !== g.ov) begin
            n_err++;
            $display("FAIL w4 %0h-%0h: got diff=%0h bo=%0b ov=%0b, expected diff=%0h bo=%0b ov=%0b",
                     a, b, if4.diff, if4.borrow, if4.overflow, g.diff, g.bo, g.ov);
        end
        n_cmp++;
    endtask

    initial begin
        int   lat, bsy;
        exp_t e;
        tbl[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
        tbl[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
        tbl[2] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
        tbl[3] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
        tbl[4] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
        tbl[5] = '{8'h80, 8'h80, 8'h00, 1'b0, 1'b0};
        tbl[6] = '{8'hFF, 8'h80, 8'h7F, 1'b0, 1'b0};
        tbl[7] = '{8'h00, 8'h80, 8'h80, 1'b1, 1'b1};

        if8.start = 1'b0; if8.a = '0; if8.b = '0;
        if4.start = 1'b0; if4.a = '0; if4.b = '0;

        #2 rst_n = 1'b0;
        #1;
        chk("rst_diff",   {24'h0, if8.diff}, 0);
        chk("rst_borrow", {31'h0, if8.borrow}, 0);
        chk("rst_ovf",    {31'h0, if8.overflow}, 0);
        chk("rst_busy",   {31'h0, if8.busy}, 0);
        chk("rst_done",   {31'h0, if8.done}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (tbl[i]) begin
            e.diff = {24'h0, tbl[i].diff};
            e.bo   = tbl[i].bo;
            e.ov   = tbl[i].ov;
            op8(tbl[i].a, tbl[i].b, e, $sformatf("vec%0d", i));
        end

        // start raised mid-run must not disturb the operation in flight
        if8.start = 1'b1; if8.a = 8'h05; if8.b = 8'h03;
        sb.push_back('{32'h02, 1'b0, 1'b0});
        @(posedge clk);
        @(negedge clk);
        if8.start = 1'b0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        if8.start = 1'b1; if8.a = 8'hFF; if8.b = 8'h00;
        wait8(1'b0, 8'h00, lat, bsy);
        chk("ign_latency", lat + 2, 8);
        pop_cmp8("ign");
        @(posedge clk);
        @(negedge clk);
        chk("ign_idle_busy", {31'h0, if8.busy}, 0);

        // reset in the middle of a run
        if8.start = 1'b1; if8.a = 8'h10; if8.b = 8'h01;
        sb.push_back('{32'h0F, 1'b0, 1'b0});
        @(posedge clk);
        @(negedge clk);
        if8.start = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("mrst_diff",   {24'h0, if8.diff}, 0);
        chk("mrst_borrow", {31'h0, if8.borrow}, 0);
        chk("mrst_ovf",    {31'h0, if8.overflow}, 0);
        chk("mrst_busy",   {31'h0, if8.busy}, 0);
        repeat (3) begin
            @(negedge clk);
            chk("mrst_no_done", {31'h0, if8.done}, 0);
        end
        rst_n = 1'b1;
        op8(8'h10, 8'h01, '{32'h0F, 1'b0, 1'b0}, "post_rst");

        // back-to-back: second start held in the done cycle
        if8.start = 1'b1; if8.a = 8'h09; if8.b = 8'h04;
        sb.push_back('{32'h05, 1'b0, 1'b0});
        @(posedge clk);
        @(negedge clk);
        if8.start = 1'b0;
        wait8(1'b0, 8'h00, lat, bsy);
        chk("b2b_first_lat", lat, 8);
        pop_cmp8("b2b_first");
        if8.start = 1'b1; if8.a = 8'h01; if8.b = 8'h02;
        sb.push_back('{32'hFF, 1'b1, 1'b0});
        wait8(1'b1, 8'h05, lat, bsy);
        chk("b2b_gap", lat, 9);
        chk("b2b_busy_cycles", bsy, 8);
        pop_cmp8("b2b_second");
        @(posedge clk);
        @(negedge clk);
        chk("b2b_done_1cyc", {31'h0, if8.done}, 0);

        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                op4(4'(a), 4'(b));

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
